// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - state_t     : responder FSM states
//   - op_t        : latched operation kind
//   - DEF_DATA_W  : default data word width
//   - ADDR_LSB    : byte-address bit where the word index starts
//   - addr_illegal: alignment / range check on a byte address
package dmem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int ADDR_LSB   = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  // True when the byte address is not word aligned or its word index
  // falls outside an array of 'depth' words.
  function automatic logic addr_illegal(input logic [31:0] addr,
                                        input int unsigned depth);
    logic [31:0] word;
    word = addr >> ADDR_LSB;
    return (addr[ADDR_LSB-1:0] != '0) || (word >= depth);
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W.
//   clk   : clock
//   we    : write enable, writes wdata to mem[idx]
//   re    : read enable, loads mem[idx] into the rdata register
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, holds its value while re is low
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset; a reset port on a
  // RAM prevents mapping to a real macro, and consumers mask rdata until a
  // read has actually completed.
  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder at the MEM end of the pipeline.
// Accepts an active-low read/write strobe, holds the pipeline with
// DmemStall for WAIT_CYC wait states, then performs the array access and
// reports completion with a one-cycle DmemValid pulse (DmemErr qualifies it).
//   CLK, RSTB  : clock, asynchronous active-low reset
//   DmemREB    : read request, active-low
//   DmemWEB    : write request, active-low
//   DmemAddr   : byte address, word index is DmemAddr[31:2]
//   DmemWData  : write data
//   DmemRData  : read data, holds between reads, 0 after reset or an error
//   DmemStall  : high while an access is outstanding
//   DmemValid  : one-cycle completion pulse
//   DmemErr    : access was illegal and was not performed
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              DmemREB,
  input  logic              DmemWEB,
  input  logic [31:0]       DmemAddr,
  input  logic [DATA_W-1:0] DmemWData,
  output logic [DATA_W-1:0] DmemRData,
  output logic              DmemStall,
  output logic              DmemValid,
  output logic              DmemErr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

  if (WAIT_CYC < 0 || WAIT_CYC > 7) begin : g_bad_wait_cyc
    $error("dmem_responder: WAIT_CYC=%0d is outside 0..7", WAIT_CYC);
  end

  if (DEPTH < 1) begin : g_bad_depth
    $error("dmem_responder: DEPTH=%0d must be at least 1", DEPTH);
  end

  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  // Access captured at acceptance.
  op_t               op_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;

  // Set once a legal read has loaded the array read register; cleared by
  // reset or an illegal access so DmemRData reads back as 0.
  logic rd_show;

  // Live request decode.
  logic req;
  op_t  req_op;
  logic req_err;

  assign req     = !DmemREB || !DmemWEB;
  assign req_op  = !DmemWEB ? OP_WR : OP_RD;
  assign req_err = addr_illegal(DmemAddr, DEPTH) || (!DmemREB && !DmemWEB);

  logic accept;
  logic commit;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYC == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the commit edge is also the acceptance edge, so
  // the array must see the live inputs rather than the latched copy.
  op_t               cur_op;
  logic              cur_err;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_wdata;

  assign cur_op    = (state == IDLE) ? req_op : op_q;
  assign cur_err   = (state == IDLE) ? req_err : err_q;
  assign cur_idx   = (state == IDLE) ? DmemAddr[ADDR_LSB +: IDX_W] : idx_q;
  assign cur_wdata = (state == IDLE) ? DmemWData : wdata_q;

  logic              sram_we;
  logic              sram_re;
  logic [DATA_W-1:0] sram_rdata;

  assign sram_we = commit && (cur_op == OP_WR) && !cur_err;
  assign sram_re = commit && (cur_op == OP_RD) && !cur_err;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      op_q    <= OP_RD;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_show <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_q    <= req_op;
        err_q   <= req_err;
        idx_q   <= DmemAddr[ADDR_LSB +: IDX_W];
        wdata_q <= DmemWData;
      end
      if (commit) begin
        if (cur_err) begin
          rd_show <= 1'b0;
        end else if (cur_op == OP_RD) begin
          rd_show <= 1'b1;
        end
      end
    end
  end

  dmem_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (CLK),
    .we    (sram_we),
    .re    (sram_re),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (sram_rdata)
  );

  assign DmemRData = rd_show ? sram_rdata : '0;
  assign DmemValid = (state == RESP);
  assign DmemErr   = (state == RESP) && err_q;
  // Stall is forced low during reset even if a request is still presented.
  assign DmemStall = RSTB && (((state == IDLE) && req) || (state == WAIT));

endmodule
